uart_tx: RTL and testbench
==========================

# uart_tx

Transmit-side framing stage of the UART. Accepts a parallel byte over a valid/ready handshake, serialises it LSB-first as start / data / optional parity / stop bits on `tx_o`, and paces every bit period with the UART baud counter. It drives the counter's enable and clear inputs and consumes its overflow flag. It sits between the processor-side UART register interface and the baud counter / TX pin.

## Interface
- `DATA_WIDTH`, 8: data bits per frame. Legal range 5–9.
- `STOP_BITS`, 1: number of stop bits. Only 1 or 2 are legal; any other value is an elaboration error.
- `clk_i` input 1: the block's single clock.
- `rst_i` input 1: synchronous, active-high reset.
- `tx_data_i` input DATA_WIDTH: byte to send; sampled on handshake.
- `tx_valid_i` input 1: upstream has data.
- `tx_ready_o` output 1: block can accept; high only in IDLE.
- `baud_tick_i` input 1: baud counter overflow (level, sticky until cleared).
- `baud_en_o` output 1: baud counter enable.
- `baud_clear_o` output 1: baud counter clear; one-cycle pulse.
- `tx_o` output 1: serial line; idle high.
- `busy_o` output 1: frame in progress (not IDLE).

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Handshake is `tx_valid_i && tx_ready_o` at a rising edge.
  - On handshake: latch `tx_data_i` into the shift register, compute even parity as the XOR of the data bits, and go to START.
- Every bit state (START, DATA, PARITY, STOP) has an entry cycle followed by counting cycles:
  - Entry cycle (first cycle in the state, or first cycle of a new DATA/STOP bit): `baud_clear_o=1`, `baud_en_o=0`.
  - Counting cycles: `baud_clear_o=0`, `baud_en_o=1`.
  - The bit ends on a counting cycle that sees `baud_tick_i=1`.
  - `baud_tick_i` is ignored during the entry cycle, because a stale sticky flag from the previous bit is still present.
- Bit values on `tx_o`:
  - START drives 0.
  - DATA drives `shift[0]`. At each bit end, shift right and increment the bit counter. After bit DATA_WIDTH-1 ends, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY drives the latched parity bit.
  - STOP drives 1. It runs STOP_BITS bit periods, each with its own entry cycle, then returns to IDLE.
- `tx_o` is registered and changes on the same edge as the state change.
- Bit counter width is `$clog2(DATA_WIDTH)`; it resets to 0 on entering DATA.
- The block never accepts data outside IDLE. A `tx_valid_i` held high during a frame is accepted in the first IDLE cycle after the frame.

## Timing
- Reset values: `tx_o=1`, `tx_ready_o=1`, `busy_o=0`, `baud_en_o=0`, `baud_clear_o=0`, state IDLE, shift register and bit counter 0.
- Reset mid-frame: the frame is abandoned. On the first edge with `rst_i=1` all outputs take their reset values, and `tx_o` returns high immediately.
- Handshake edge → the next cycle is the START entry cycle: `tx_o=0`, `baud_clear_o=1`, `tx_ready_o=0`, `busy_o=1`.
- Bit period = 1 entry cycle + the number of counting cycles until `baud_tick_i`.
- Last stop bit's tick → IDLE on the next edge, with `tx_ready_o=1` in that cycle. The minimum inter-frame gap is 1 idle cycle.
- A `baud_tick_i` arriving in the same cycle as `rst_i` is ignored; reset wins.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and one even-parity bit is inserted after the data bits.
- `UART_TX_PARITY_EN` undefined: the PARITY state, the parity register and parity logic are absent, and DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg`:
  - typedef `uart_tx_state_e` (IDLE, START, DATA, PARITY, STOP).
  - constants `UART_IDLE_LEVEL=1'b1`, `UART_START_LEVEL=1'b0`.
- No sub-module; single flat module. The baud counter is instantiated beside this block at the UART top level.

## Test plan
All scenarios use a baud stub that raises `baud_tick_i` on the 5th consecutive `baud_en_o` cycle and lowers it on clear, giving 6-cycle bits.
- Reset then idle: `tx_o=1`, `tx_ready_o=1`, `busy_o=0`, `baud_*=0` for 20 cycles.
- Send 0xA5, no parity, 1 stop: `tx_o` sequence 0,1,0,1,0,0,1,0,1,1, each level held for 6 cycles (60 cycles total). `tx_ready_o` returns on cycle 61.
- Send 0x07 with `UART_TX_PARITY_EN`, STOP_BITS=2: bits 0,1,1,1,0,0,0,0,0, parity 1, stop 1,1 (12 bits, 72 cycles).
- `tx_valid_i` held high with 0x11 then 0x22: two back-to-back frames separated by exactly 1 idle cycle. The second byte is accepted only when `tx_ready_o=1`.
- Stale tick: force `baud_tick_i=1` during an entry cycle → no state advance. `baud_clear_o` pulses exactly once per bit.
- Assert `rst_i` during data bit 3: next edge `tx_o=1`, `busy_o=0`. A new frame of 0x3C then transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and serial line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// UART transmit framing: start / LSB-first data / optional even parity / stop bits,
// paced by an external baud counter. Define UART_TX_PARITY_EN to insert the parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  input  logic                  baud_tick_i,
  output logic                  baud_en_o,
  output logic                  baud_clear_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int                CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx: DATA_WIDTH must be in 5..9");
  end

  uart_tx_state_e        state_q, state_d;
  logic                  entry_q, entry_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  tx_q, tx_d;
  logic                  bit_done;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      entry_q    <= 1'b0;
      // NOTE: the shift register is reset too, so an abandoned frame leaves
      // no residue visible to the next one.
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // The tick is only trusted on counting cycles; during an entry cycle the
  // counter's sticky flag still reflects the previous bit.
  assign bit_done = (state_q != IDLE) && !entry_q && baud_tick_i;

  // NOTE: every signal assigned below gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    entry_d    = 1'b0;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_valid_i && tx_ready_o) begin
          state_d = START;
          entry_d = 1'b1;
          shift_d = tx_data_i;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data_i;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          entry_d   = 1'b1;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          entry_d = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d    = STOP;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d    = STOP;
          entry_d    = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
            entry_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered, so it changes on the same edge.
    tx_d = UART_IDLE_LEVEL;
    case (state_d)
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_comb begin
    tx_ready_o   = (state_q == IDLE);
    busy_o       = (state_q != IDLE);
    baud_clear_o = busy_o && entry_q;
    baud_en_o    = busy_o && !entry_q;
  end

  assign tx_o = tx_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a baud stub gives 6-cycle bits, a frame model
// queues expected line levels, and a negedge monitor checks every cycle.
module tb_uart_tx;

  localparam int DW      = 8;
  localparam int BIT_CYC = 6;
`ifdef UART_TX_PARITY_EN
  localparam int SB  = 2;
  localparam int PAR = 1;
`else
  localparam int SB  = 1;
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready_o, baud_tick, baud_en_o, baud_clear_o, tx_o, busy_o;
  logic          stale_force, rst_force;
  int            stub_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic lv[16];
    int   n;
    int   gap;
  } frame_t;

  frame_t exp_q[$];
  frame_t cur;
  bit     mon_active = 1'b0;
  int     bit_idx, cyc, idle_cnt;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW), .STOP_BITS(SB)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready_o),
    .baud_tick_i (baud_tick),
    .baud_en_o   (baud_en_o),
    .baud_clear_o(baud_clear_o),
    .tx_o        (tx_o),
    .busy_o      (busy_o)
  );

  // Baud stub: flag goes high on the 5th consecutive enable cycle, sticks until clear.
  always @(posedge clk) begin
    if (rst_i || baud_clear_o) stub_cnt <= 0;
    else if (baud_en_o && stub_cnt < 5) stub_cnt <= stub_cnt + 1;
  end
  assign baud_tick = (stub_cnt >= 4) || (stale_force && baud_clear_o) || rst_force;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_t model(input int d, input int gap);
    frame_t f;
    int ones = 0;
    int b;
    for (int i = 0; i < 16; i++) f.lv[i] = 1'b1;
    f.gap = gap;
    f.lv[0] = 1'b0;
    f.n = 1;
    for (int i = 0; i < DW; i++) begin
      b = (d / (1 << i)) % 2;
      ones += b;
      f.lv[f.n] = (b == 1);
      f.n += 1;
    end
    if (PAR == 1) begin
      f.lv[f.n] = (ones % 2 == 1);
      f.n += 1;
    end
    f.n += SB;
    return f;
  endfunction

  // Monitor: pops one expected frame when busy rises, checks each cycle of it.
  always @(negedge clk) begin
    if (rst_i) begin
      mon_active = 1'b0;
      idle_cnt   = 0;
    end else begin
      if (!mon_active) begin
        if (busy_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            cur        = exp_q.pop_front();
            mon_active = 1'b1;
            bit_idx    = 0;
            cyc        = 0;
            if (cur.gap >= 0) check("idle_gap", idle_cnt, cur.gap);
          end
        end else begin
          idle_cnt++;
          check("idle_tx", tx_o, 1);
          check("idle_ready", tx_ready_o, 1);
          check("idle_baud_en_clear", {baud_en_o, baud_clear_o}, 0);
        end
      end
      if (mon_active) begin
        check($sformatf("tx_bit%0d", bit_idx), tx_o, cur.lv[bit_idx]);
        check("busy_in_frame", busy_o, 1);
        check("ready_in_frame", tx_ready_o, 0);
        check("baud_clear", baud_clear_o, (cyc == 0));
        check("baud_en", baud_en_o, (cyc != 0));
        cyc++;
        if (cyc == BIT_CYC) begin
          cyc = 0;
          bit_idx++;
          if (bit_idx == cur.n) begin
            mon_active = 1'b0;
            idle_cnt   = 0;
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (!tx_ready_o && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("ready_timeout", (w >= 300), 0);
  endtask

  task automatic send(input logic [DW-1:0] d, input int gap_exp, input logic stale);
    @(negedge clk);
    tx_data     = d;
    tx_valid    = 1'b1;
    stale_force = stale;
    wait_ready();
    exp_q.push_back(model(int'(d), gap_exp));
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((mon_active || exp_q.size() != 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("frame_drained", int'(mon_active) + exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"}, tx_o, 1);
    check({tag, "_ready"}, tx_ready_o, 1);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_baud_en"}, baud_en_o, 0);
    check({tag, "_baud_clear"}, baud_clear_o, 0);
  endtask

  initial begin
    rst_i = 1'b1; tx_valid = 1'b0; tx_data = '0; stale_force = 1'b0; rst_force = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_i = 1'b0;
    repeat (20) @(negedge clk);

    send(8'hA5, -1, 1'b0);
    wait_drain();
    send(8'h07, -1, 1'b1);
    wait_drain();

    // Valid held across two frames: second byte must wait for the single idle cycle.
    @(negedge clk);
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    exp_q.push_back(model(32'h11, -1));
    @(posedge clk);
    #1 tx_data = 8'h22;
    @(negedge clk);
    wait_ready();
    exp_q.push_back(model(32'h22, 1));
    @(posedge clk);
    #1 tx_valid = 1'b0;
    wait_drain();

    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(DW'($urandom), -1, 1'($urandom));
    end
    wait_drain();

    // Reset in the middle of data bit 3, then a clean frame.
    send(DW'($urandom), -1, 1'b0);
    repeat (26) @(negedge clk);
    rst_i = 1'b1;
    rst_force = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("midframe_reset");
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    rst_force = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h3C, -1, 1'b0);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_tx
